tx_chunk_arbiter: RTL
=====================

Name: tx_chunk_arbiter

Overview:
- Shares the single UART byte transmitter between N virtual peripherals: display, LEDs, and other chunk producers.
- Each producer raises `should_update` and holds `tx_chunk_type` / `tx_chunk_bytes` stable.
- The arbiter grants one producer by round-robin, latches its chunk, and serialises it as [type, payload byte 0 .. payload byte P-1].
- After the last byte is accepted, it pulses that producer's acknowledge, which is wired to the producer's `reset` handshake input.

Parameters:
- NUM_SOURCES, 4, number of chunk producers (2..8).
- PAYLOAD_BYTES, 2, payload bytes per chunk; a producer's chunk data is PAYLOAD_BYTES*8 bits wide.
- SRC_INDEX_SIZE, 2, bits needed to index NUM_SOURCES.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- src_should_update  in  NUM_SOURCES  per-source request level.
- src_chunk_type  in  NUM_SOURCES*8  flattened; source i occupies [i*8 +: 8].
- src_chunk_bytes  in  NUM_SOURCES*PAYLOAD_BYTES*8  flattened; source i occupies [i*PAYLOAD_BYTES*8 +: PAYLOAD_BYTES*8].
- src_enable  in  NUM_SOURCES  request mask; a disabled source is never granted.
- src_ack  out  NUM_SOURCES  one-hot, one-cycle pulse: chunk of source i fully sent.
- tx_valid  out  1  tx_data holds a byte to send.
- tx_data  out  8  byte to UART transmitter.
- tx_ready  in  1  transmitter accepts the byte on a cycle where tx_valid && tx_ready.
- busy  out  1  high whenever state != IDLE.
- grant_index  out  SRC_INDEX_SIZE  index of the current or last granted source.

Behaviour:
- Reset (async, RST_N low):
  - state=IDLE; src_ack=0, tx_valid=0, tx_data=0, busy=0, grant_index=0.
  - rr pointer=0, so source 0 has highest priority.
  - Any in-flight chunk is abandoned with no ack; the source keeps requesting and is resent after reset releases.
- States: IDLE, SEND, ACK.
- IDLE:
  - eligible = src_should_update & src_enable.
  - If eligible != 0: pick the first set bit scanning from rr pointer upward, wrapping modulo NUM_SOURCES.
  - At the clock edge: latch type and payload of the winner into a shift/holding register, set grant_index, byte_cnt=0, go to SEND.
  - Latency: the request cycle is followed by tx_valid high in the very next cycle.
- SEND:
  - tx_valid=1. tx_data = type when byte_cnt=0, otherwise payload byte (byte_cnt-1), taken from bits [(byte_cnt-1)*8 +: 8].
  - On tx_valid && tx_ready: byte_cnt++. When byte_cnt == PAYLOAD_BYTES and the byte is accepted, go to ACK.
  - tx_valid never drops and tx_data never changes while not accepted.
  - The source's inputs are ignored after latching, so changes mid-send do not corrupt the frame.
- ACK (exactly one cycle):
  - src_ack[grant_index]=1; tx_valid=0.
  - rr pointer = grant_index+1, wrapping NUM_SOURCES-1 to 0. Go to IDLE.
  - src_ack is decoded from the state register, so it is glitch-free and asserted for one full cycle.
- Source contract: the producer drops `should_update` by the cycle after the ack, or presents a new chunk then. IDLE samples requests no earlier than the cycle after ACK, so no chunk is duplicated.
- Disabling a source mid-send has no effect on the current chunk.
- Simultaneous requests are resolved purely by the rr pointer. Requests arriving during SEND/ACK wait.
- Throughput with tx_ready tied high: one chunk per PAYLOAD_BYTES+3 cycles (5 for defaults).
- Width rules:
  - byte_cnt is clog2(PAYLOAD_BYTES+1) bits.
  - The rr pointer compare is done modulo NUM_SOURCES, never modulo a power of two, so a non-power-of-2 NUM_SOURCES wraps correctly.

Decomposition:
- Shared package `chunk_defs`:
  - chunk type constants: LEDS, DISPLAY=6, etc.
  - arbiter state encodings IDLE/SEND/ACK.
  - CHUNK_TYPE_WIDTH=8.
- Sub-module `rr_priority_picker`: combinational input eligible mask plus pointer, outputs found flag plus index. Reused later by an RX-side dispatcher.

Test Plan:
- Single source: src1 requests type=0x06, bytes=0x5A03, tx_ready=1 → tx bytes 0x06, 0x03, 0x5A on consecutive cycles; src_ack=4'b0010 for one cycle; 5 cycles from request to IDLE.
- Round-robin: sources 0, 2, 3 request continuously after reset → grant order 0, 2, 3, 0, 2 …; no source served twice while another is waiting.
- Backpressure: tx_ready low for 7 cycles during payload byte 0 → tx_valid stays high and tx_data stays 0x03 throughout; the frame completes unchanged once ready rises.
- Mid-send input change: source changes src_chunk_bytes to 0xFFFF after grant → the original bytes are sent; the new value goes out as the next chunk only if still requested after ack.
- Mask: src_enable=4'b1011 with all four sources requesting → source 2 is never granted; setting the bit grants it within one round.
- Async reset during SEND byte 1 → all outputs 0 immediately without waiting for a clock; after release the same source's chunk is resent from the type byte; no ack was issued for the aborted frame.

Source files
------------

// File: rtl/chunk_defs.sv
// Shared definitions for the chunk transport: chunk type codes,
// arbiter state encodings and the chunk type field width.
package chunk_defs;

  localparam int CHUNK_TYPE_WIDTH = 8;

  localparam logic [CHUNK_TYPE_WIDTH-1:0] CHUNK_TYPE_LEDS    = 8'h01;
  localparam logic [CHUNK_TYPE_WIDTH-1:0] CHUNK_TYPE_BUTTONS = 8'h02;
  localparam logic [CHUNK_TYPE_WIDTH-1:0] CHUNK_TYPE_DISPLAY = 8'h06;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: finds the first eligible source scanning upward from
// the pointer, wrapping modulo NUM_SOURCES (not modulo a power of two).
module rr_priority_picker #(
  parameter int NUM_SOURCES    = 4,
  parameter int SRC_INDEX_SIZE = 2
) (
  input  logic [NUM_SOURCES-1:0]    eligible,
  input  logic [SRC_INDEX_SIZE-1:0] pointer,
  output logic                      found,
  output logic [SRC_INDEX_SIZE-1:0] index
);

  // Scan offsets 0..N-1 from the pointer and keep the first eligible hit.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int off = 0; off < NUM_SOURCES; off++) begin
      int   cand;
      logic cand_bit;
      cand = int'(pointer) + off;
      if (cand >= NUM_SOURCES) cand = cand - NUM_SOURCES;
      cand_bit = 1'b0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (i == cand) cand_bit = eligible[i];
      end
      if (!found && cand_bit) begin
        found = 1'b1;
        index = SRC_INDEX_SIZE'(cand);
      end
    end
  end

endmodule

// File: rtl/tx_chunk_arbiter.sv
// Shares one UART byte transmitter between several chunk producers.
// A granted chunk is latched and sent as [type, payload 0 .. payload P-1],
// then the producer is acknowledged with a one-cycle src_ack pulse.
module tx_chunk_arbiter
  import chunk_defs::*;
#(
  parameter int NUM_SOURCES    = 4,
  parameter int PAYLOAD_BYTES  = 2,
  parameter int SRC_INDEX_SIZE = 2
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic [NUM_SOURCES-1:0]                src_should_update,
  input  logic [NUM_SOURCES*CHUNK_TYPE_WIDTH-1:0] src_chunk_type,
  input  logic [NUM_SOURCES*PAYLOAD_BYTES*8-1:0] src_chunk_bytes,
  input  logic [NUM_SOURCES-1:0]                src_enable,
  output logic [NUM_SOURCES-1:0]                src_ack,
  output logic                                  tx_valid,
  output logic [7:0]                            tx_data,
  input  logic                                  tx_ready,
  output logic                                  busy,
  output logic [SRC_INDEX_SIZE-1:0]             grant_index
);

  localparam int CHUNK_BITS = PAYLOAD_BYTES * 8;
  localparam int CNT_W      = $clog2(PAYLOAD_BYTES + 1);

  arb_state_t                  state;
  arb_state_t                  next_state;
  logic [CNT_W-1:0]            byte_cnt;
  logic [CHUNK_TYPE_WIDTH-1:0] type_q;
  logic [CHUNK_BITS-1:0]       payload_q;
  logic [SRC_INDEX_SIZE-1:0]   rr_ptr;
  logic [NUM_SOURCES-1:0]      eligible;
  logic                        pick_found;
  logic [SRC_INDEX_SIZE-1:0]   pick_index;
  logic [CHUNK_TYPE_WIDTH-1:0] winner_type;
  logic [CHUNK_BITS-1:0]       winner_payload;
  logic [7:0]                  payload_byte;
  logic                        last_byte;

  assign eligible  = src_should_update & src_enable;
  assign last_byte = (byte_cnt == CNT_W'(PAYLOAD_BYTES));

  rr_priority_picker #(
    .NUM_SOURCES   (NUM_SOURCES),
    .SRC_INDEX_SIZE(SRC_INDEX_SIZE)
  ) u_picker (
    .eligible(eligible),
    .pointer (rr_ptr),
    .found   (pick_found),
    .index   (pick_index)
  );

  // Select the winning source's type and payload from the flattened buses.
  always_comb begin
    winner_type    = '0;
    winner_payload = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (pick_index == SRC_INDEX_SIZE'(i)) begin
        winner_type    = src_chunk_type[i*CHUNK_TYPE_WIDTH +: CHUNK_TYPE_WIDTH];
        winner_payload = src_chunk_bytes[i*CHUNK_BITS +: CHUNK_BITS];
      end
    end
  end

  // Pick the latched payload byte addressed by byte_cnt-1.
  always_comb begin
    payload_byte = '0;
    for (int k = 0; k < PAYLOAD_BYTES; k++) begin
      if (byte_cnt == CNT_W'(k + 1)) payload_byte = payload_q[k*8 +: 8];
    end
  end

  // State register; reset abandons any in-flight chunk without an ack.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: grant on any eligible request, leave SEND after the
  // last byte is accepted, and spend exactly one cycle in ACK.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_found) next_state = SEND;
      SEND:    if (tx_ready && last_byte) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch the granted chunk, count accepted bytes, advance the
  // round-robin pointer past the source just served.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      byte_cnt    <= '0;
      type_q      <= '0;
      payload_q   <= '0;
      grant_index <= '0;
      rr_ptr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            type_q      <= winner_type;
            payload_q   <= winner_payload;
            grant_index <= pick_index;
            byte_cnt    <= '0;
          end
        end
        SEND: begin
          if (tx_ready && !last_byte) byte_cnt <= byte_cnt + 1'b1;
        end
        ACK: begin
          rr_ptr <= (grant_index == SRC_INDEX_SIZE'(NUM_SOURCES - 1)) ?
                    '0 : grant_index + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state register so src_ack is glitch-free.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    src_ack  = '0;
    busy     = (state != IDLE);
    case (state)
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = (byte_cnt == '0) ? type_q : payload_byte;
      end
      ACK: begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
          if (grant_index == SRC_INDEX_SIZE'(i)) src_ack[i] = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
